// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_memory between the CPU (port 0) and a
// debug/DMA master (port 1). Each access runs IDLE -> ACCESS -> DONE, so a
// new access can start every third cycle.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration.
// Without it, port 0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              grant;
    logic              grant_port;
    logic              we_q;
    logic              port_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef DMEM_ARB_RR_EN
    logic last_grant;

    // Winner selection: on a contest, the port that did not win last time goes
    always_comb begin
        grant      = p0_req | p1_req;
        grant_port = p1_req & (~p0_req | ~last_grant);
    end

    // Remember which port won the most recent grant (1 after reset so port 0 wins first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= 1'b1;
        else if (state == IDLE && grant)
            last_grant <= grant_port;
    end
`else
    // Winner selection: port 0 always wins a contest
    always_comb begin
        grant      = p0_req | p1_req;
        grant_port = p1_req & ~p0_req;
    end
`endif

    // State register; reset aborts any in-flight access immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state, one-cycle memory strobes and one-cycle ack to the latched port
    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        p0_ack    = 1'b0;
        p1_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (grant)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_read  = ~we_q;
                mem_write = we_q;
                state_nxt = DONE;
            end
            DONE: begin
                p0_ack    = ~port_q;
                p1_ack    = port_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winning request at grant; capture read data (or clear on write) in ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            port_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && grant) begin
                port_q  <= grant_port;
                we_q    <= grant_port ? p1_we    : p0_we;
                addr_q  <= grant_port ? p1_addr  : p0_addr;
                wdata_q <= grant_port ? p1_wdata : p0_wdata;
            end
            if (state == ACCESS)
                rdata_q <= we_q ? '0 : mem_rdata;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p0_rdata  = rdata_q;
    assign p1_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized transactions against a
// transaction-level reference (word memory + arbitration rule).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic        p0_ack;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_ack;
    logic [31:0] p1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          model_last = 1;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // data_memory stand-in: word addressed by bits [9:2], combinational read
    always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The two strobes must never be high together
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            assert (!(mem_read === 1'b1 && mem_write === 1'b1)) else begin
                n_err++;
                $error("FAIL strobe_excl observed=%b%b expected=not-both", mem_read, mem_write);
            end
        end
    end

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef DMEM_ARB_RR_EN
        return (model_last == 1) ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    // One transaction, entered and left at a falling edge with the arbiter idle
    task automatic txn(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                       input bit scr, input int exp_port);
        int          w;
        bit          we;
        logic [31:0] a, d, exp_rd;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        if (!r0 && !r1) begin
            @(posedge clk); @(negedge clk);
            chk("idle_strobes", {30'b0, mem_read, mem_write}, 32'd0);
            chk("idle_acks", {30'b0, p0_ack, p1_ack}, 32'd0);
            return;
        end
        w = pick(r0, r1);
        if (exp_port >= 0) chk("winner", w, exp_port);
        model_last = w;
        we = (w == 0) ? w0 : w1;
        a  = (w == 0) ? a0 : a1;
        d  = (w == 0) ? d0 : d1;
        @(posedge clk); @(negedge clk);
        chk("acc_read", mem_read, !we);
        chk("acc_write", mem_write, we);
        chk("acc_addr", mem_addr, a);
        if (we) chk("acc_wdata", mem_wdata, d);
        chk("acc_acks", {30'b0, p0_ack, p1_ack}, 32'd0);
        if (scr) begin
            p0_req = 1'b0; p1_req = 1'b0;
            p0_addr = $urandom; p1_addr = $urandom;
            p0_wdata = $urandom; p1_wdata = $urandom;
            p0_we = $urandom_range(0, 1); p1_we = $urandom_range(0, 1);
        end
        exp_rd = we ? 32'd0 : ref_mem[a[9:2]];
        if (we) ref_mem[a[9:2]] = d;
        @(posedge clk); @(negedge clk);
        chk("done_p0_ack", p0_ack, w == 0);
        chk("done_p1_ack", p1_ack, w == 1);
        chk("done_p0_rdata", p0_rdata, exp_rd);
        chk("done_p1_rdata", p1_rdata, exp_rd);
        chk("done_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("post_acks", {30'b0, p0_ack, p1_ack}, 32'd0);
        chk("post_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_acks", {30'b0, p0_ack, p1_ack}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", p0_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle with no request
        txn(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);

        // P0 write then read back
        txn(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        txn(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);

        // Contest: both read, loser held and served next
        txn(1, 0, 32'h10, 0, 1, 0, 32'h40, 0, 0, -1);
        txn(0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 1);

        // Four contests with both requests held
        for (int k = 0; k < 4; k++)
            txn(1, 0, 32'h10, 0, 1, 0, 32'h10, 0, 0, -1);

        // P1 drops req and changes address right after grant
        txn(0, 0, 0, 0, 1, 1, 32'h84, 32'hCAFEF00D, 1, 1);
        txn(1, 0, 32'h84, 0, 0, 0, 0, 0, 0, 0);

        // Reset during the ACCESS cycle of a write
        p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'h12345678;
        p1_req = 0;
        @(posedge clk); @(negedge clk);
        chk("rstw_acc_write", mem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstw_write_drop", mem_write, 1'b0);
        p0_req = 0;
        @(posedge clk); @(negedge clk);
        chk("rstw_ack_a", {30'b0, p0_ack, p1_ack}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("rstw_ack_b", {30'b0, p0_ack, p1_ack}, 32'd0);
        chk("rstw_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        model_last = 1;
        @(negedge clk);
        txn(1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0);

        // P1 write/read at top of memory window
        txn(0, 0, 0, 0, 1, 1, 32'h3FC, 32'hA5A5A5A5, 0, 1);
        txn(0, 0, 0, 0, 1, 0, 32'h3FC, 0, 0, 1);

        // Randomized traffic with aliasing upper/low address bits
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra0, ra1;
            ra0 = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            ra1 = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            txn($urandom_range(0, 3) != 0, $urandom_range(0, 1), ra0, $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1), ra1, $urandom,
                $urandom_range(0, 1), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
